// File: rtl/data_mem_if_pkg.sv
// Shared constants for the data-memory load/store responder: funct3 codes,
// FSM encoding, base opcodes and lane/legality helpers.
package data_mem_if_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr);
        case (size)
            2'b00:   return 4'b0001 << addr;
            2'b01:   return addr[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Conflicting strobes, an unknown funct3 or a misaligned address all end
    // the access without touching the bus.
    function automatic logic access_error(input logic rd, input logic wr,
                                          input logic [2:0] f3, input logic [1:0] addr);
        logic bad_enc;
        logic bad_align;
        if (rd && wr)
            return 1'b1;
        if (rd)
            bad_enc = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        else
            bad_enc = !(f3 inside {F3_B, F3_H, F3_W});
        bad_align = ((f3[1:0] == 2'b01) && addr[0]) || ((f3[1:0] == 2'b10) && (addr != 2'b00));
        return bad_enc || bad_align;
    endfunction

endpackage

// File: rtl/data_mem_if_lsu_load_align.sv
// Load formatter: picks the byte/halfword lane from the bus word and applies
// sign or zero extension according to funct3.
module lsu_load_align
    import data_mem_if_pkg::*;
(
    input  logic [2:0]  i_Funct3,
    input  logic [1:0]  i_Lane,
    input  logic [31:0] i_RData,
    output logic [31:0] o_Data
);

    logic signed [7:0]  w_Byte;
    logic signed [15:0] w_Half;

    always_comb begin
        case (i_Lane)
            2'd0:    w_Byte = i_RData[7:0];
            2'd1:    w_Byte = i_RData[15:8];
            2'd2:    w_Byte = i_RData[23:16];
            default: w_Byte = i_RData[31:24];
        endcase
        w_Half = i_Lane[1] ? i_RData[31:16] : i_RData[15:0];
    end

    always_comb begin
        case (i_Funct3)
            F3_B:    o_Data = 32'(w_Byte);
            F3_BU:   o_Data = {24'd0, w_Byte};
            F3_H:    o_Data = 32'(w_Half);
            F3_HU:   o_Data = {16'd0, w_Half};
            default: o_Data = i_RData;
        endcase
    end

endmodule

// File: rtl/data_mem_if.sv
// Load/store responder: one request/acknowledge word transaction per access,
// stalling the pipeline until completion. Optional bus timeout: LSU_TIMEOUT_EN.
module data_mem_if
    import data_mem_if_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_MemRead,
    input  logic        i_MemWrite,
    input  logic [2:0]  i_Funct3,
    input  logic [31:0] i_Addr,
    input  logic [31:0] i_WData,
    output logic        o_Stall,
    output logic        o_Valid,
    output logic [31:0] o_RData,
    output logic        o_Misaligned,
    output logic        o_BusErr,
    output logic        o_BusReq,
    output logic        o_BusWe,
    output logic [31:0] o_BusAddr,
    output logic [3:0]  o_BusBe,
    output logic [31:0] o_BusWData,
    input  logic        i_BusAck,
    input  logic [31:0] i_BusRData
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit the 8-bit wait counter (1..255)");
    end

    state_t      r_State, w_Next;
    logic [31:0] r_Addr, r_WData, r_RData;
    logic [3:0]  r_Be;
    logic [2:0]  r_Funct3;
    logic        r_We, r_Err, r_BusErr;
    logic        w_Strobe, w_Err, w_Timeout;
    logic [3:0]  w_Be;
    logic [31:0] w_WData, w_LoadData;

    assign w_Strobe = i_MemRead | i_MemWrite;
    assign w_Err    = access_error(i_MemRead, i_MemWrite, i_Funct3, i_Addr[1:0]);
    assign w_Be     = lane_mask(i_Funct3[1:0], i_Addr[1:0]);

    always_comb begin
        case (i_Funct3[1:0])
            2'b00:   w_WData = {4{i_WData[7:0]}};
            2'b01:   w_WData = {2{i_WData[15:0]}};
            default: w_WData = i_WData;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    logic [7:0] r_Cnt;
    assign w_Timeout = (r_State == ST_BUSY) && !i_BusAck && ((r_Cnt + 8'd1) == 8'(TIMEOUT_CYCLES));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_Cnt <= 8'd0;
        else if (r_State == ST_IDLE)
            r_Cnt <= 8'd0;
        else if (r_State == ST_BUSY && !i_BusAck)
            r_Cnt <= r_Cnt + 8'd1;
    end
`else
    assign w_Timeout = 1'b0;
`endif

    lsu_load_align u_align (
        .i_Funct3 (r_Funct3),
        .i_Lane   (r_Addr[1:0]),
        .i_RData  (i_BusRData),
        .o_Data   (w_LoadData)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_State <= ST_IDLE;
        else
            r_State <= w_Next;
    end

    always_comb begin
        w_Next = r_State;
        case (r_State)
            ST_IDLE: if (w_Strobe) w_Next = w_Err ? ST_DONE : ST_BUSY;
            ST_BUSY: if (i_BusAck || w_Timeout) w_Next = ST_DONE;
            default: w_Next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_Addr   <= '0;
            r_WData  <= '0;
            r_RData  <= '0;
            r_Be     <= '0;
            r_Funct3 <= '0;
            r_We     <= 1'b0;
            r_Err    <= 1'b0;
            r_BusErr <= 1'b0;
        end else if (r_State == ST_IDLE && w_Strobe) begin
            r_Addr   <= i_Addr;
            r_WData  <= w_WData;
            r_RData  <= '0;
            r_Be     <= w_Be;
            r_Funct3 <= i_Funct3;
            r_We     <= i_MemWrite;
            r_Err    <= w_Err;
            r_BusErr <= 1'b0;
        end else if (r_State == ST_BUSY) begin
            // Acknowledge takes priority over a timeout in the same cycle.
            if (i_BusAck)
                r_RData <= r_We ? 32'd0 : w_LoadData;
            else if (w_Timeout)
                r_BusErr <= 1'b1;
        end
    end

    always_comb begin
        o_Stall      = (r_State == ST_BUSY) || (r_State == ST_IDLE && w_Strobe);
        o_Valid      = (r_State == ST_DONE);
        o_RData      = (r_State == ST_DONE) ? r_RData : 32'd0;
        o_Misaligned = (r_State == ST_DONE) && r_Err;
        o_BusErr     = (r_State == ST_DONE) && r_BusErr;
        o_BusReq     = (r_State == ST_BUSY);
        o_BusWe      = (r_State == ST_BUSY) && r_We;
        o_BusAddr    = (r_State == ST_BUSY) ? {r_Addr[31:2], 2'b00} : 32'd0;
        o_BusBe      = (r_State == ST_BUSY) ? r_Be : 4'd0;
        o_BusWData   = (r_State == ST_BUSY) ? r_WData : 32'd0;
    end

endmodule

// File: tb/tb_data_mem_if.sv
// Directed bench for data_mem_if; the timeout scenario runs when LSU_TIMEOUT_EN is defined.
module tb_data_mem_if;
    import data_mem_if_pkg::*;

`ifdef LSU_TIMEOUT_EN
    localparam int TB_TMO = 4;
`else
    localparam int TB_TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemRead = 1'b0, MemWrite = 1'b0;
    logic [2:0]  Funct3 = 3'd0;
    logic [31:0] Addr = 32'd0, WData = 32'd0;
    logic        Stall, Valid, Mis, BusErr, BusReq, BusWe;
    logic [31:0] RData, BusAddr, BusWData;
    logic [3:0]  BusBe;
    logic        BusAck = 1'b0;
    logic [31:0] BusRData = 32'd0;

    int n_chk = 0;
    int n_fail = 0;

    data_mem_if #(.TIMEOUT_CYCLES(TB_TMO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_MemRead(MemRead), .i_MemWrite(MemWrite), .i_Funct3(Funct3),
        .i_Addr(Addr), .i_WData(WData),
        .o_Stall(Stall), .o_Valid(Valid), .o_RData(RData),
        .o_Misaligned(Mis), .o_BusErr(BusErr),
        .o_BusReq(BusReq), .o_BusWe(BusWe), .o_BusAddr(BusAddr),
        .o_BusBe(BusBe), .o_BusWData(BusWData),
        .i_BusAck(BusAck), .i_BusRData(BusRData)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required<200000", $time);
        $fatal(1);
    end

    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = a; WData = wd;
        #1;
    endtask

    task automatic drop_strobes();
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_chk++;
        if ({Stall, Valid, Mis, BusErr, BusReq, BusWe} !== 6'b0 || RData !== 32'd0 ||
            BusAddr !== 32'd0 || BusBe !== 4'd0 || BusWData !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ctl=%b rdata=%h addr=%h be=%b wd=%h, expected all zero",
                     {Stall, Valid, Mis, BusErr, BusReq, BusWe}, RData, BusAddr, BusBe, BusWData);
        end
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (Stall !== 1'b0 || BusReq !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_quiet: got stall=%b req=%b expected 0 0", Stall, BusReq);
        end
    endtask

    // Load with optional wait cycles; checks lane mask and formatted result.
    task automatic test_load(input string name, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] bus, input int waits,
                             input logic [3:0] exp_be, input logic [31:0] exp_rd);
        @(negedge clk);
        issue(1'b1, 1'b0, f3, a, 32'd0);
        n_chk++;
        if (Stall !== 1'b1 || BusReq !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_c0: got stall=%b req=%b expected 1 0", name, Stall, BusReq);
        end
        drop_strobes();
        for (int w = 0; w < waits; w++) begin
            @(negedge clk);
            n_chk++;
            if (Stall !== 1'b1 || BusReq !== 1'b1 || Valid !== 1'b0 || BusBe !== exp_be) begin
                n_fail++;
                $display("FAIL %s_wait%0d: got stall=%b req=%b valid=%b be=%b expected 1 1 0 %b",
                         name, w, Stall, BusReq, Valid, BusBe, exp_be);
            end
        end
        @(negedge clk);
        n_chk++;
        if (BusReq !== 1'b1 || BusWe !== 1'b0 || Stall !== 1'b1 || BusBe !== exp_be ||
            BusAddr !== {a[31:2], 2'b00}) begin
            n_fail++;
            $display("FAIL %s_busy: got req=%b we=%b stall=%b be=%b addr=%h expected 1 0 1 %b %h",
                     name, BusReq, BusWe, Stall, BusBe, BusAddr, exp_be, {a[31:2], 2'b00});
        end
        BusAck = 1'b1; BusRData = bus;
        @(posedge clk); #1;
        BusAck = 1'b0; BusRData = 32'hA5A5A5A5;
        @(negedge clk);
        n_chk++;
        if (Valid !== 1'b1 || RData !== exp_rd || Stall !== 1'b0 || Mis !== 1'b0 ||
            BusErr !== 1'b0 || BusReq !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done: got valid=%b rdata=%h stall=%b mis=%b berr=%b req=%b expected 1 %h 0 0 0 0",
                     name, Valid, RData, Stall, Mis, BusErr, BusReq, exp_rd);
        end
        @(negedge clk);
        n_chk++;
        if (Valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_pulse: got valid=%b expected 0", name, Valid);
        end
    endtask

    task automatic test_store(input string name, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [3:0] exp_be,
                              input logic [31:0] exp_wd);
        @(negedge clk);
        issue(1'b0, 1'b1, f3, a, wd);
        drop_strobes();
        @(negedge clk);
        n_chk++;
        if (BusReq !== 1'b1 || BusWe !== 1'b1 || BusAddr !== {a[31:2], 2'b00} ||
            BusBe !== exp_be || BusWData !== exp_wd) begin
            n_fail++;
            $display("FAIL %s_bus: got req=%b we=%b addr=%h be=%b wd=%h expected 1 1 %h %b %h",
                     name, BusReq, BusWe, BusAddr, BusBe, BusWData, {a[31:2], 2'b00}, exp_be, exp_wd);
        end
        BusAck = 1'b1;
        @(posedge clk); #1;
        BusAck = 1'b0;
        @(negedge clk);
        n_chk++;
        if (Valid !== 1'b1 || RData !== 32'd0 || Mis !== 1'b0 || BusWe !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done: got valid=%b rdata=%h mis=%b we=%b expected 1 0 0 0",
                     name, Valid, RData, Mis, BusWe);
        end
    endtask

    task automatic test_error(input string name, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] a);
        logic saw_req;
        @(negedge clk);
        issue(rd, wr, f3, a, 32'hFFFF_FFFF);
        saw_req = BusReq;
        n_chk++;
        if (Stall !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_c0: got stall=%b expected 1", name, Stall);
        end
        drop_strobes();
        @(negedge clk);
        saw_req = saw_req | BusReq;
        n_chk++;
        if (Valid !== 1'b1 || Mis !== 1'b1 || Stall !== 1'b0 || RData !== 32'd0 || saw_req !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_c1: got valid=%b mis=%b stall=%b rdata=%h req_seen=%b expected 1 1 0 0 0",
                     name, Valid, Mis, Stall, RData, saw_req);
        end
        @(negedge clk);
        n_chk++;
        if (Valid !== 1'b0 || Mis !== 1'b0 || BusReq !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_after: got valid=%b mis=%b req=%b expected 0 0 0", name, Valid, Mis, BusReq);
        end
    endtask

    task automatic test_async_reset();
        logic saw_valid;
        @(negedge clk);
        issue(1'b1, 1'b0, F3_W, 32'h0000_0300, 32'd0);
        drop_strobes();
        @(negedge clk);
        n_chk++;
        if (BusReq !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_busy: got req=%b expected 1", BusReq);
        end
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if (BusReq !== 1'b0 || Stall !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_drop: got req=%b stall=%b expected 0 0 without a clock edge", BusReq, Stall);
        end
        #1 rst = 1'b0;
        saw_valid = 1'b0;
        @(negedge clk);
        BusAck = 1'b1; BusRData = 32'h1111_2222;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            saw_valid = saw_valid | Valid | BusReq;
        end
        BusAck = 1'b0;
        n_chk++;
        if (saw_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_late_ack: got valid_or_req=%b expected 0", saw_valid);
        end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        @(negedge clk);
        issue(1'b1, 1'b0, F3_W, 32'h0000_0400, 32'd0);
        drop_strobes();
        BusRData = 32'hFFFF_FFFF;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            n_chk++;
            if (BusReq !== 1'b1 || Valid !== 1'b0) begin
                n_fail++;
                $display("FAIL tmo_busy%0d: got req=%b valid=%b expected 1 0", c, BusReq, Valid);
            end
        end
        @(negedge clk);
        n_chk++;
        if (Valid !== 1'b1 || BusErr !== 1'b1 || RData !== 32'd0 || BusReq !== 1'b0 || Mis !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_done: got valid=%b berr=%b rdata=%h req=%b mis=%b expected 1 1 0 0 0",
                     Valid, BusErr, RData, BusReq, Mis);
        end
        @(negedge clk);
        n_chk++;
        if (BusErr !== 1'b0 || Valid !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_after: got berr=%b valid=%b expected 0 0", BusErr, Valid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load("lw",  F3_W,  32'h0000_0100, 32'hDEAD_BEEF, 0, 4'b1111, 32'hDEAD_BEEF);
        test_load("lb",  F3_B,  32'h0000_0103, 32'h8012_3456, 0, 4'b1000, 32'hFFFF_FF80);
        test_load("lbu", F3_BU, 32'h0000_0103, 32'h8012_3456, 0, 4'b1000, 32'h0000_0080);
        test_load("lh",  F3_H,  32'h0000_0102, 32'h8012_3456, 2, 4'b1100, 32'hFFFF_8012);
        test_load("lhu", F3_HU, 32'h0000_0100, 32'h8012_B456, 1, 4'b0011, 32'h0000_B456);
        test_load("lb1", F3_B,  32'h0000_0101, 32'h8012_3456, 0, 4'b0010, 32'h0000_0034);
        test_store("sh", F3_H, 32'h0000_0202, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD);
        test_store("sb", F3_B, 32'h0000_0001, 32'h0000_00AB, 4'b0010, 32'hABAB_ABAB);
        test_store("sw", F3_W, 32'h0000_0010, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
        test_error("lw_mis",   1'b1, 1'b0, F3_W,   32'h0000_0102);
        test_error("both",     1'b1, 1'b1, F3_W,   32'h0000_0100);
        test_error("lh_mis",   1'b1, 1'b0, F3_H,   32'h0000_0101);
        test_error("ld_enc",   1'b1, 1'b0, 3'b011, 32'h0000_0100);
        test_error("st_enc",   1'b0, 1'b1, F3_BU,  32'h0000_0100);
        test_async_reset();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
